dflow_tuple_replayer: RTL and testbench
=======================================

Name: dflow_tuple_replayer

Overview:
- Parametrised successor to the dflow 5-tuple generator core.
- Captures a stream of {5-tuple, pkt_len} records into an on-chip buffer, then replays the buffer a programmable number of passes with a programmable inter-record gap.
- Optional per-pass src_ip increment turns one captured trace into many distinct flows.
- Sits between the tuple source and the downstream tuple consumer, controlled from the rw register bank.

Parameters:
PKT_TUPLE_WIDTH, 104, tuple width; layout {src_ip[103:72], dst_ip[71:40], src_port[39:24], dst_port[23:8], proto[7:0]}
PKT_LEN_WIDTH, 16, packet length field width
BUF_ADDR_WIDTH, 10, buffer depth = 2**BUF_ADDR_WIDTH records
REPLAY_COUNT_WIDTH, 32, pass counter width
GAP_WIDTH, 16, inter-record gap counter width

Ports:
clk  in  1  core clock
resetn  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous soft reset, level
store_en  in  1  capture enable, level
replay_en  in  1  replay enable, level
incr_mode  in  1  1 = add pass index to src_ip on output
replay_count  in  REPLAY_COUNT_WIDTH  passes to run; 0 = unlimited
gap_cycles  in  GAP_WIDTH  idle cycles inserted after each accepted output record
fivetuple_data_in  in  PKT_TUPLE_WIDTH  input tuple
pkt_len_in  in  PKT_LEN_WIDTH  input length
tuple_in_vld  in  1  input valid
tuple_in_ready  out  1  input ready
fivetuple_data_out  out  PKT_TUPLE_WIDTH  output tuple
pkt_len_out  out  PKT_LEN_WIDTH  output length
tuple_out_vld  out  1  output valid
tuple_out_ready  in  1  output ready
stored_count  out  BUF_ADDR_WIDTH+1  records held in buffer
pass_done_cnt  out  REPLAY_COUNT_WIDTH  completed passes
busy  out  1  state != IDLE
replay_done  out  1  one-cycle pulse when replay ends

Behaviour:
- Reset (resetn low, async) or sw_rst high (sync, highest priority):
  - state=IDLE; all outputs 0; stored_count=0; pass_done_cnt=0.
  - Buffer contents are don't-care.
- store_en and replay_en are edge-detected internally (registered copy).
- Handshake on both sides: transfer when vld && ready.
  - tuple_out_vld, once high, stays high with data stable until accepted.
- IDLE:
  - store_en rise -> STORE; write pointer and stored_count clear to 0.
  - replay_en rise -> REPLAY; read pointer=0, pass=0, pass_done_cnt=0.
  - If both rise in the same cycle, STORE wins.
- STORE:
  - tuple_in_ready = (stored_count < 2**BUF_ADDR_WIDTH).
  - Each input transfer writes one record and increments stored_count.
  - When full, ready=0 and nothing is dropped.
  - store_en fall -> IDLE; stored_count is retained.
  - replay_en is ignored in STORE.
  - tuple_in_ready=0 in every state other than STORE.
- REPLAY:
  - Synchronous buffer read with prefetch.
  - First tuple_out_vld no later than 2 cycles after the replay_en rise is sampled.
  - With tuple_out_ready=1 and gap_cycles=0, sustains 1 record/cycle.
  - Read pointer wraps from stored_count-1 to 0; each wrap increments pass and pass_done_cnt.
  - Output tuple = stored tuple, except when incr_mode=1: src_ip field = stored src_ip + pass (mod 2**32; pass truncated/zero-extended to 32). Other fields unchanged.
  - incr_mode is sampled per record.
- GAP:
  - Entered after each accepted record when gap_cycles != 0.
  - tuple_out_vld=0 for exactly gap_cycles cycles, then back to REPLAY.
- Termination:
  - replay_count != 0 and pass_done_cnt reaches replay_count -> DONE.
  - replay_en fall -> graceful stop: a pending output record completes its handshake, then DONE with no further records.
  - replay_en rise with stored_count=0 -> DONE immediately, no output.
- DONE: replay_done=1 for one cycle, then IDLE. pass_done_cnt holds its value until the next replay start.
- Counters wrap silently: pass at 2**REPLAY_COUNT_WIDTH; src_ip addition modulo 2**32.
- sw_rst mid-replay: tuple_out_vld drops next cycle even if unaccepted. This is the one permitted exception to the stable-valid rule.

Test Plan:
- Store 3 records (src_ip=0x0A000001..3, len 64/128/256), replay_count=2, gap=0, ready=1 -> 6 outputs back-to-back in order; pass_done_cnt=2; one replay_done pulse.
- Same buffer, incr_mode=1, replay_count=3 -> second pass src_ip=0x0A000002..4, third pass 0x0A000003..5; other fields identical.
- BUF_ADDR_WIDTH=2: offer 6 inputs during STORE -> exactly 4 accepted, tuple_in_ready=0 afterward, stored_count=4.
- gap_cycles=3, ready=1 -> exactly 3 idle cycles between consecutive valid records. Random ready toggling -> data held stable while vld && !ready.
- replay_count=0, drop replay_en after 10 accepts with ready stalled on the 11th -> 11th completes when ready rises, then replay_done; no 12th record.
- replay_en with stored_count=0 -> replay_done within 3 cycles, no valid. sw_rst mid-replay -> busy=0, vld=0, stored_count=0 next cycle.

Source files
------------

// File: rtl/dflow_tuple_replayer.sv
// Captures a stream of {5-tuple, pkt_len} records into an on-chip buffer and
// replays it a programmable number of passes with an optional per-pass src_ip offset.
module dflow_tuple_replayer #(
  parameter int PKT_TUPLE_WIDTH    = 104,
  parameter int PKT_LEN_WIDTH      = 16,
  parameter int BUF_ADDR_WIDTH     = 10,
  parameter int REPLAY_COUNT_WIDTH = 32,
  parameter int GAP_WIDTH          = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          sw_rst,
  input  logic                          store_en,
  input  logic                          replay_en,
  input  logic                          incr_mode,
  input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
  input  logic [GAP_WIDTH-1:0]          gap_cycles,
  input  logic [PKT_TUPLE_WIDTH-1:0]    fivetuple_data_in,
  input  logic [PKT_LEN_WIDTH-1:0]      pkt_len_in,
  input  logic                          tuple_in_vld,
  output logic                          tuple_in_ready,
  output logic [PKT_TUPLE_WIDTH-1:0]    fivetuple_data_out,
  output logic [PKT_LEN_WIDTH-1:0]      pkt_len_out,
  output logic                          tuple_out_vld,
  input  logic                          tuple_out_ready,
  output logic [BUF_ADDR_WIDTH:0]       stored_count,
  output logic [REPLAY_COUNT_WIDTH-1:0] pass_done_cnt,
  output logic                          busy,
  output logic                          replay_done
);

  localparam int DEPTH = 2 ** BUF_ADDR_WIDTH;
  localparam int REC_W = PKT_TUPLE_WIDTH + PKT_LEN_WIDTH;

  localparam logic [BUF_ADDR_WIDTH:0]       CNT_ONE  = {{BUF_ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [BUF_ADDR_WIDTH-1:0]     PTR_ONE  = {{(BUF_ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REPLAY_COUNT_WIDTH-1:0] PASS_ONE = {{(REPLAY_COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [GAP_WIDTH-1:0]          GAP_ONE  = {{(GAP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {S_IDLE, S_STORE, S_REPLAY, S_GAP, S_DONE} state_t;

  state_t                          state_q;
  logic                            store_en_q, replay_en_q, stop_q, done_q;
  logic [BUF_ADDR_WIDTH-1:0]       rd_ptr_q, rd_ptr_d;
  logic [BUF_ADDR_WIDTH:0]         cnt_q;
  logic [REPLAY_COUNT_WIDTH-1:0]   pass_q;
  logic [GAP_WIDTH-1:0]            gap_q;
  logic [PKT_TUPLE_WIDTH-1:0]      out_tuple_q;
  logic [PKT_LEN_WIDTH-1:0]        out_len_q;
  logic                            out_vld_q;

  logic [REC_W-1:0]                mem [DEPTH];
  logic [REC_W-1:0]                mem_q;

  logic store_rise, store_fall, replay_rise, replay_fall;
  logic full, in_xfer, accept, stop, count_hit, can_load, last_rec, slot_free, load;

  // Output tuple with the pass index added to the src_ip field (top 32 bits).
  function automatic logic [PKT_TUPLE_WIDTH-1:0] replay_tuple(
    input logic [PKT_TUPLE_WIDTH-1:0]    t,
    input logic [REPLAY_COUNT_WIDTH-1:0] pass,
    input logic                          incr
  );
    logic [31:0] pass32;
    pass32 = 32'(pass);
    replay_tuple = t;
    if (incr) replay_tuple[PKT_TUPLE_WIDTH-1 -: 32] = t[PKT_TUPLE_WIDTH-1 -: 32] + pass32;
  endfunction

  assign store_rise  = store_en & ~store_en_q;
  assign store_fall  = ~store_en & store_en_q;
  assign replay_rise = replay_en & ~replay_en_q;
  assign replay_fall = ~replay_en & replay_en_q;

  assign full      = cnt_q[BUF_ADDR_WIDTH];
  assign in_xfer   = (state_q == S_STORE) && !full && tuple_in_vld;
  assign accept    = out_vld_q && tuple_out_ready;
  assign stop      = stop_q || replay_fall;
  assign count_hit = (replay_count != '0) && (pass_q == replay_count);
  assign can_load  = !stop && !count_hit;
  assign last_rec  = ({1'b0, rd_ptr_q} == (cnt_q - CNT_ONE));
  assign slot_free = !out_vld_q || accept;

  // With a nonzero gap, an accept hands over to GAP instead of refilling; the
  // last GAP cycle refills so the idle stretch is exactly gap_cycles long.
  assign load = can_load &&
                (((state_q == S_REPLAY) && slot_free && !(accept && (gap_cycles != '0))) ||
                 ((state_q == S_GAP) && (gap_q == GAP_ONE)));

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if ((state_q == S_IDLE) && !store_rise && replay_rise) rd_ptr_d = '0;
    else if (load) rd_ptr_d = last_rec ? '0 : rd_ptr_q + PTR_ONE;
  end

  // Buffer: write during capture, read always tracks the next read pointer so
  // mem_q holds the record at rd_ptr_q (prefetch).
  always_ff @(posedge clk) begin
    if (in_xfer) mem[cnt_q[BUF_ADDR_WIDTH-1:0]] <= {fivetuple_data_in, pkt_len_in};
    mem_q <= mem[rd_ptr_d];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      store_en_q  <= 1'b0;
      replay_en_q <= 1'b0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      pass_q      <= '0;
      gap_q       <= '0;
      out_tuple_q <= '0;
      out_len_q   <= '0;
      out_vld_q   <= 1'b0;
    end else begin
      store_en_q  <= store_en;
      replay_en_q <= replay_en;
      if (sw_rst) begin
        state_q     <= S_IDLE;
        stop_q      <= 1'b0;
        done_q      <= 1'b0;
        rd_ptr_q    <= '0;
        cnt_q       <= '0;
        pass_q      <= '0;
        gap_q       <= '0;
        out_tuple_q <= '0;
        out_len_q   <= '0;
        out_vld_q   <= 1'b0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        done_q   <= 1'b0;
        if (load) begin
          out_tuple_q <= replay_tuple(mem_q[REC_W-1 -: PKT_TUPLE_WIDTH], pass_q, incr_mode);
          out_len_q   <= mem_q[PKT_LEN_WIDTH-1:0];
          out_vld_q   <= 1'b1;
          if (last_rec) pass_q <= pass_q + PASS_ONE;
        end else if (accept) begin
          out_vld_q <= 1'b0;
        end
        case (state_q)
          S_IDLE: begin
            if (store_rise) begin
              state_q <= S_STORE;
              cnt_q   <= '0;
            end else if (replay_rise) begin
              pass_q <= '0;
              stop_q <= 1'b0;
              if (cnt_q == '0) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= S_REPLAY;
              end
            end
          end
          S_STORE: begin
            if (in_xfer) cnt_q <= cnt_q + CNT_ONE;
            if (store_fall) state_q <= S_IDLE;
          end
          S_REPLAY: begin
            if (replay_fall) stop_q <= 1'b1;
            if (slot_free && !can_load) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (accept && (gap_cycles != '0)) begin
              state_q <= S_GAP;
              gap_q   <= gap_cycles;
            end
          end
          S_GAP: begin
            if (replay_fall) stop_q <= 1'b1;
            if (!can_load) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              gap_q <= gap_q - GAP_ONE;
              if (gap_q == GAP_ONE) state_q <= S_REPLAY;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign tuple_in_ready     = (state_q == S_STORE) && !full;
  assign fivetuple_data_out = out_tuple_q;
  assign pkt_len_out        = out_len_q;
  assign tuple_out_vld      = out_vld_q;
  assign stored_count       = cnt_q;
  assign pass_done_cnt      = pass_q;
  assign busy               = (state_q != S_IDLE);
  assign replay_done        = done_q;

endmodule

// File: tb/tb_dflow_tuple_replayer.sv
// Randomized bench for dflow_tuple_replayer: a queue-based model of capture and
// replay predicts every output record; one negedge process compares against it.
module tb_dflow_tuple_replayer;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         resetn = 1'b0, sw_rst = 1'b0, store_en = 1'b0, replay_en = 1'b0, incr_mode = 1'b0;
  logic [31:0]  replay_count = '0;
  logic [15:0]  gap_cycles = '0;
  logic [103:0] tin = '0;
  logic [15:0]  lin = '0;
  logic         tin_vld = 1'b0, tuple_out_ready = 1'b1;
  logic         tuple_in_ready, tuple_out_vld, busy, replay_done;
  logic [103:0] tout;
  logic [15:0]  lout;
  logic [AW:0]  stored_count;
  logic [31:0]  pass_done_cnt;

  dflow_tuple_replayer #(.BUF_ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn), .sw_rst(sw_rst), .store_en(store_en), .replay_en(replay_en),
    .incr_mode(incr_mode), .replay_count(replay_count), .gap_cycles(gap_cycles),
    .fivetuple_data_in(tin), .pkt_len_in(lin), .tuple_in_vld(tin_vld), .tuple_in_ready(tuple_in_ready),
    .fivetuple_data_out(tout), .pkt_len_out(lout), .tuple_out_vld(tuple_out_vld),
    .tuple_out_ready(tuple_out_ready), .stored_count(stored_count), .pass_done_cnt(pass_done_cnt),
    .busy(busy), .replay_done(replay_done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc++;

  logic [103:0] m_tup[$], st_tup[$], exp_tup[$];
  logic [15:0]  m_len[$], st_len[$], exp_len[$];
  logic [31:0]  got_src[$];
  logic [15:0]  got_len[$];

  int  rdy_mode = 0;
  bit  chk_spacing = 0, have_prev = 0, first_seen = 0;
  int  exp_gap = 0, last_acc = 0, first_cyc = 0, done_cnt = 0, acc_cnt = 0;
  bit  prev_hold = 0, prev_sw = 0, prev_done = 0;
  logic [119:0] prev_data = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rdy_mode == 1) tuple_out_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [103:0] mk(input logic [31:0] s, input logic [31:0] d,
                                      input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] pr);
    return {s, d, sp, dp, pr};
  endfunction

  // Expected stream: record k of the replay is buffer entry k mod n in pass k / n.
  task automatic build(input int total, input bit incr);
    int n;
    logic [103:0] t;
    n = m_tup.size();
    exp_tup.delete(); exp_len.delete();
    for (int k = 0; k < total; k++) begin
      t = m_tup[k % n];
      if (incr) t[103:72] = t[103:72] + 32'(k / n);
      exp_tup.push_back(t);
      exp_len.push_back(m_len[k % n]);
    end
  endtask

  // Compare process: every output record against the model queue.
  always @(negedge clk) begin
    if (resetn && !sw_rst) begin
      if (prev_hold && !prev_sw) begin
        chk("vld_held", tuple_out_vld, 1'b1);
        chk("data_held", {tout, lout}, prev_data);
      end
      if (tuple_out_vld) begin
        if (!first_seen) begin first_seen = 1; first_cyc = cyc; end
        if (exp_tup.size() == 0) chk("unexpected_vld", tuple_out_vld, 1'b0);
        else if (tuple_out_ready) begin
          chk("out_tuple", tout, exp_tup.pop_front());
          chk("out_len", lout, exp_len.pop_front());
          got_src.push_back(tout[103:72]);
          got_len.push_back(lout);
          if (chk_spacing && have_prev) chk("spacing", 32'(cyc - last_acc), 32'(exp_gap + 1));
          have_prev = 1; last_acc = cyc; acc_cnt++;
        end
      end
      if (replay_done) begin
        done_cnt++;
        if (prev_done) chk("done_pulse_width", prev_done, 1'b0);
      end
    end
    prev_hold = tuple_out_vld && !tuple_out_ready;
    prev_data = {tout, lout};
    prev_sw   = sw_rst;
    prev_done = replay_done;
  end

  task automatic do_store();
    bit acc;
    m_tup.delete(); m_len.delete();
    store_en = 1'b1; tick();
    for (int i = 0; i < st_tup.size(); i++) begin
      tin = st_tup[i]; lin = st_len[i]; tin_vld = 1'b1;
      @(negedge clk);
      acc = (m_tup.size() < DEPTH);
      chk("in_ready", tuple_in_ready, acc);
      @(posedge clk); #1;
      if (acc) begin m_tup.push_back(st_tup[i]); m_len.push_back(st_len[i]); end
    end
    tin_vld = 1'b0; store_en = 1'b0; tick(); tick();
    chk("stored_count", stored_count, m_tup.size());
    chk("in_ready_idle", tuple_in_ready, 1'b0);
  endtask

  task automatic wait_done(input int base, input int budget);
    int k = 0;
    while (done_cnt == base && k < budget) begin tick(); k++; end
    chk("done_seen", done_cnt != base, 1'b1);
  endtask

  task automatic do_replay(input int passes, input int gap, input bit incr, input int mode);
    int base, start;
    replay_count = passes; gap_cycles = 16'(gap); incr_mode = incr;
    rdy_mode = mode; tuple_out_ready = 1'b1;
    build(passes * m_tup.size(), incr);
    got_src.delete(); got_len.delete();
    chk_spacing = (mode == 0); exp_gap = gap; have_prev = 0; first_seen = 0;
    base = done_cnt;
    replay_en = 1'b1; start = cyc;
    wait_done(base, passes * m_tup.size() * (gap + 2) * 4 + 40);
    chk("first_vld_seen", first_seen, 1'b1);
    chk("first_vld_latency_ok", (first_cyc - start) <= 3, 1'b1);
    chk("all_records_out", exp_tup.size(), 0);
    chk("pass_done_cnt", pass_done_cnt, passes);
    replay_en = 1'b0; rdy_mode = 0; tuple_out_ready = 1'b1;
    tick(); tick();
    chk("done_pulses", done_cnt - base, 1);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, k;
    repeat (2) @(negedge clk);
    chk("rst_vld", tuple_out_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stored", stored_count, 0);
    chk("rst_tuple", tout, 0);
    @(posedge clk); #1; resetn = 1'b1;
    tick();
    chk("post_rst_ready", tuple_in_ready, 1'b0);
    chk("post_rst_pass", pass_done_cnt, 0);
    chk("post_rst_done", replay_done, 1'b0);

    // Three records, two plain passes
    st_tup.delete(); st_len.delete();
    for (int i = 0; i < 3; i++) begin
      st_tup.push_back(mk(32'h0A000001 + 32'(i), 32'hC0A80001, 16'(1000 + i), 16'd80, 8'd6));
      st_len.push_back(16'd64 << i);
    end
    do_store();
    do_replay(2, 0, 0, 0);
    chk("lit_len2", got_len[2], 16'd256);
    chk("lit_src4", got_src[4], 32'h0A000002);
    chk("lit_count6", got_src.size(), 6);

    // Same buffer, incrementing src_ip, three passes
    do_replay(3, 0, 1, 0);
    chk("lit_incr_src3", got_src[3], 32'h0A000002);
    chk("lit_incr_src8", got_src[8], 32'h0A000005);

    // Inter-record gap, then random backpressure
    do_replay(2, 3, 0, 0);
    do_replay(2, 1, 1, 1);

    // Unlimited replay, graceful stop with the 11th record stalled
    build(11, 0);
    replay_count = 0; gap_cycles = 0; incr_mode = 0; rdy_mode = 0; tuple_out_ready = 1'b1;
    chk_spacing = 1; exp_gap = 0; have_prev = 0; first_seen = 0; acc_cnt = 0; base = done_cnt;
    replay_en = 1'b1; k = 0;
    while (acc_cnt < 10 && k < 200) begin tick(); k++; end
    chk("ten_accepted", acc_cnt, 10);
    tuple_out_ready = 1'b0; replay_en = 1'b0; chk_spacing = 0;
    repeat (4) tick();
    chk("no_done_while_stalled", done_cnt - base, 0);
    tuple_out_ready = 1'b1;
    wait_done(base, 20);
    repeat (4) tick();
    chk("stop_all_out", exp_tup.size(), 0);
    chk("stop_done_pulses", done_cnt - base, 1);
    chk("stop_pass_cnt", pass_done_cnt, 3);

    // Overfill: six offers into a four-entry buffer
    st_tup.delete(); st_len.delete();
    for (int i = 0; i < 6; i++) begin
      st_tup.push_back(mk($urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom)));
      st_len.push_back(16'($urandom));
    end
    do_store();
    chk("lit_full_count", stored_count, 4);
    do_replay(1, 0, 0, 0);

    // Random rounds
    for (int r = 0; r < 6; r++) begin
      st_tup.delete(); st_len.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
        st_tup.push_back(mk(($urandom_range(0, 2) == 0) ? 32'hFFFFFFFE : $urandom, $urandom,
                            16'($urandom), 16'($urandom), 8'($urandom)));
        st_len.push_back(16'($urandom));
      end
      do_store();
      do_replay($urandom_range(1, 3), $urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(0, 1));
    end

    // Soft reset in the middle of a replay
    st_tup.delete(); st_len.delete();
    for (int i = 0; i < 3; i++) begin
      st_tup.push_back(mk($urandom, $urandom, 16'($urandom), 16'($urandom), 8'($urandom)));
      st_len.push_back(16'($urandom));
    end
    do_store();
    build(15, 1);
    replay_count = 5; gap_cycles = 0; incr_mode = 1; chk_spacing = 0; first_seen = 0;
    rdy_mode = 1; base = done_cnt;
    replay_en = 1'b1;
    repeat (6) tick();
    sw_rst = 1'b1; replay_en = 1'b0; exp_tup.delete(); exp_len.delete();
    tick();
    sw_rst = 1'b0; rdy_mode = 0; tuple_out_ready = 1'b1;
    @(negedge clk);
    chk("swrst_busy", busy, 1'b0);
    chk("swrst_vld", tuple_out_vld, 1'b0);
    chk("swrst_stored", stored_count, 0);
    chk("swrst_pass", pass_done_cnt, 0);
    tick();
    chk("swrst_no_done", done_cnt - base, 0);

    // Replay with an empty buffer
    base = done_cnt;
    replay_count = 1;
    replay_en = 1'b1;
    wait_done(base, 3);
    replay_en = 1'b0;
    repeat (3) tick();
    chk("empty_done_pulses", done_cnt - base, 1);
    chk("empty_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
